game_tick_ctrl: RTL and testbench

Programmable game-tick controller. It owns one period counter and turns it into a one-cycle `tick` strobe plus a 50%-duty `slow_clk` square wave. Game logic drives it through start/stop/pause controls, a `level_up` speed-up request and a valid/ready period-load handshake. It sits between the top-level control FSM and every game-state register that advances once per game step.

---
 rtl/game_tick_ctrl_if.sv | 16 +
 rtl/game_tick_ctrl.sv | 143 ++++++++++++++
 tb/tb_game_tick_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_ctrl_if.sv
// Period-load channel between game logic (master) and game_tick_ctrl (slave).
//
// Handshake: a transfer happens on the rising clock edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on the slave's state and
// never on cfg_valid. The master keeps cfg_valid and cfg_count stable until
// it sees that edge. A cfg_valid seen while cfg_ready is low is not queued.
interface game_tick_ctrl_if #(
    parameter int WIDTH = 28
) ();
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_count;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_count, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_count, output cfg_ready);
endinterface

// File: rtl/game_tick_ctrl.sv
// Programmable game-tick controller: one period counter produces a one-cycle
// tick strobe and a 50%-duty slow_clk. The block is controlled by
// start/stop/pause, by level_up speed-up requests and by a period-load channel.
module game_tick_ctrl #(
    parameter int               WIDTH      = 28,
    parameter logic [WIDTH-1:0] BASE_COUNT = 28'd12_499_999,
    parameter logic [WIDTH-1:0] STEP       = 28'd1_000_000,
    parameter logic [WIDTH-1:0] MIN_COUNT  = 28'd2_499_999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  level_up,
    game_tick_ctrl_if.slave       cfg,
    output logic                  tick,
    output logic                  slow_clk,
    output logic [WIDTH-1:0]      cur_count,
    output logic [15:0]           tick_cnt,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cur_count_q;
    logic             tick_q;
    logic             slow_clk_q;
    logic [15:0]      tick_cnt_q;
    logic             pending_q;

    logic             terminal;
    logic             cfg_load;
    logic [WIDTH-1:0] shortened;
    logic [WIDTH-1:0] cfg_clamped;

    // Loads are accepted only while the counter is stopped or frozen.
    assign cfg.cfg_ready = (state_q != S_RUN);
    assign cfg_load      = cfg.cfg_valid & cfg.cfg_ready;
    assign terminal      = (cnt_q == cur_count_q);

    // Candidate period values: one step shorter with a floor, and a clamped load.
    // The comparison is one bit wider so MIN_COUNT+STEP cannot wrap.
    always_comb begin
        shortened   = cur_count_q - STEP;
        cfg_clamped = cfg.cfg_count;
        if ({1'b0, cur_count_q} < ({1'b0, MIN_COUNT} + {1'b0, STEP})) begin
            shortened = MIN_COUNT;
        end
        if (cfg.cfg_count < MIN_COUNT) begin
            cfg_clamped = MIN_COUNT;
        end
    end

    // Control FSM with counter, period register and all registered outputs.
    // Edge priority: stop, then terminal count, then pause, then config load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_count_q <= BASE_COUNT;
            tick_q      <= 1'b0;
            slow_clk_q  <= 1'b0;
            tick_cnt_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                pending_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (start) begin
                            state_q    <= S_RUN;
                            tick_cnt_q <= '0;
                        end
                        if (cfg_load) begin
                            cur_count_q <= cfg_clamped;
                            pending_q   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (level_up) begin
                            pending_q <= 1'b1;
                        end
                        // The edge that sees pause still counts as a run cycle,
                        // so a tick due on it is issued before freezing.
                        if (terminal) begin
                            cnt_q      <= '0;
                            tick_q     <= 1'b1;
                            slow_clk_q <= ~slow_clk_q;
                            tick_cnt_q <= tick_cnt_q + 16'd1;
                            if (pending_q | level_up) begin
                                cur_count_q <= shortened;
                                pending_q   <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (pause) begin
                            state_q <= S_PAUSE;
                        end
                    end
                    S_PAUSE: begin
                        if (level_up) begin
                            pending_q <= 1'b1;
                        end
                        // Leaving PAUSE only re-arms counting; the counter
                        // advances from the next edge.
                        if (!pause) begin
                            state_q <= S_RUN;
                        end
                        if (cfg_load) begin
                            cur_count_q <= cfg_clamped;
                            cnt_q       <= '0;
                            pending_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign tick      = tick_q;
    assign slow_clk  = slow_clk_q;
    assign cur_count = cur_count_q;
    assign tick_cnt  = tick_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with a small period (BASE=4, STEP=1, MIN=1).
module tb_game_tick_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         pause;
    logic         level_up;
    logic         tick;
    logic         slow_clk;
    logic [W-1:0] cur_count;
    logic [15:0]  tick_cnt;
    logic [1:0]   state;

    int n_tests;
    int n_fail;
    int n;
    int n_ticks;
    int n_consec;
    logic prev_tick;
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;

    game_tick_ctrl_if #(.WIDTH(W)) cfg_if ();

    game_tick_ctrl #(
        .WIDTH      (W),
        .BASE_COUNT (8'd4),
        .STEP       (8'd1),
        .MIN_COUNT  (8'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .level_up  (level_up),
        .cfg       (cfg_if),
        .tick      (tick),
        .slow_clk  (slow_clk),
        .cur_count (cur_count),
        .tick_cnt  (tick_cnt),
        .state     (state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until tick is seen, bounded by max_cyc.
    task automatic wait_tick(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (tick !== 1'b1 && cyc < max_cyc);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        level_up = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_count = '0;

        // Reset values
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_tick", tick, 0);
        check("rst_slow", slow_clk, 0);
        check("rst_cur", cur_count, 4);
        check("rst_tick_cnt", tick_cnt, 0);
        check("rst_ready", cfg_if.cfg_ready, 1);
        rst_n = 1'b1;
        step();

        // Start and three periods of 5 cycles
        exp_q.push_back({1'b1, 16'd1});
        exp_q.push_back({1'b0, 16'd2});
        exp_q.push_back({1'b1, 16'd3});
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", state, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(40, n);
            check("period_base", n, 5);
            exp_item = exp_q.pop_front();
            check("slow_after_tick", slow_clk, exp_item[16]);
            check("tick_cnt_after_tick", tick_cnt, exp_item[15:0]);
        end

        // Pause for 7 cycles beginning 2 cycles after a tick
        step();
        check("tick_one_cycle", tick, 0);
        step();
        pause = 1'b1;
        step();
        check("pause_state", state, 2);
        repeat (6) step();
        check("pause_hold_tick_cnt", tick_cnt, 3);
        check("pause_no_tick", tick, 0);
        pause = 1'b0;
        wait_tick(40, n);
        check("pause_delay", n + 9, 12);
        check("pause_tick_cnt", tick_cnt, 4);

        // Three level_up requests in one period collapse to one step
        level_up = 1'b1;
        step();
        level_up = 1'b0;
        step();
        level_up = 1'b1;
        step();
        step();
        level_up = 1'b0;
        check("lvl_before_tick", cur_count, 4);
        step();
        check("lvl_tick", tick, 1);
        check("lvl_cur_after", cur_count, 3);
        wait_tick(40, n);
        check("lvl_period", n, 4);
        check("lvl_cur_stable", cur_count, 3);

        // Repeated level_up down to the floor
        level_up = 1'b1;
        repeat (12) step();
        check("floor_cur", cur_count, 1);
        check("floor_tick_cnt", tick_cnt, 10);
        n_ticks = 0;
        n_consec = 0;
        prev_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick === 1'b1) begin
                n_ticks++;
                if (prev_tick === 1'b1) n_consec++;
            end
            prev_tick = tick;
        end
        check("floor_ticks", n_ticks, 5);
        check("floor_consec", n_consec, 0);
        check("floor_cur_hold", cur_count, 1);
        level_up = 1'b0;

        // Config loads in PAUSE (this pause edge is also a terminal count)
        pause = 1'b1;
        step();
        check("cfg_pause_state", state, 2);
        check("cfg_pause_ready", cfg_if.cfg_ready, 1);
        check("cfg_pause_tick_cnt", tick_cnt, 16);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_count = 8'd6;
        step();
        check("cfg_load_6", cur_count, 6);
        cfg_if.cfg_count = 8'd0;
        step();
        check("cfg_load_0_clamp", cur_count, 1);
        cfg_if.cfg_count = 8'd6;
        step();
        cfg_if.cfg_valid = 1'b0;
        pause = 1'b0;
        step();
        check("cfg_resume_state", state, 1);
        wait_tick(40, n);
        check("cfg_first_period", n, 7);
        check("cfg_cur_after_tick", cur_count, 6);

        // Config request in RUN is dropped
        check("cfg_run_ready", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_count = 8'd0;
        step();
        cfg_if.cfg_valid = 1'b0;
        check("cfg_run_dropped", cur_count, 6);

        // stop on a terminal-count edge with a pending level_up
        level_up = 1'b1;
        step();
        level_up = 1'b0;
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tick", tick, 0);
        check("stop_state", state, 0);
        check("stop_cur", cur_count, 6);
        check("stop_slow", slow_clk, 1);
        check("stop_tick_cnt", tick_cnt, 17);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_tick_cnt", tick_cnt, 0);
        wait_tick(40, n);
        check("restart_period", n, 7);
        check("stop_cleared_pending", cur_count, 6);
        check("restart_tick_cnt_1", tick_cnt, 1);

        // Asynchronous reset mid-period
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_cur", cur_count, 4);
        check("arst_tick_cnt", tick_cnt, 0);
        check("arst_slow", slow_clk, 0);
        check("arst_ready", cfg_if.cfg_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        n_ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick === 1'b1) n_ticks++;
        end
        check("arst_idle_ticks", n_ticks, 0);
        check("arst_idle_state", state, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_tick(40, n);
        check("arst_restart_period", n, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
